// File: rtl/mmio_bus_fabric_if.sv
// ============================================================================
// Module  : mmio_bus_fabric_if
// Brief   : CPU-side and peripheral-side signal bundle for mmio_bus_fabric.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmio_bus_fabric_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                             cpu_req;
  logic                             cpu_we;
  logic [ADDR_WIDTH-1:0]            cpu_addr;
  logic [DATA_WIDTH-1:0]            cpu_wdata;
  logic [DATA_WIDTH-1:0]            cpu_rdata;
  logic                             cpu_ready;
  logic                             cpu_error;

  logic [NUM_SLAVES-1:0]            slv_sel;
  logic                             slv_we;
  logic [ADDR_WIDTH-1:0]            slv_addr;
  logic [DATA_WIDTH-1:0]            slv_wdata;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata;
  logic [NUM_SLAVES-1:0]            slv_ready;

  // The fabric is a slave to the CPU and a master to the peripherals.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_error
  );

  modport master (
    output slv_sel, slv_we, slv_addr, slv_wdata,
    input  slv_rdata, slv_ready
  );
endinterface

`default_nettype wire

// File: rtl/mmio_bus_fabric.sv
// ============================================================================
// Module  : mmio_bus_fabric
// Brief   : Decodes one CPU request against base/mask windows and forwards it
//           to the selected peripheral. Optional access timeout: MMIO_TIMEOUT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_bus_fabric #(
  parameter int                                NUM_SLAVES = 4,
  parameter int                                ADDR_WIDTH = 32,
  parameter int                                DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLAVE_MASK = '0,
  parameter int                                TIMEOUT    = 255
) (
  input  wire logic         clock,
  input  wire logic         reset_n,
  mmio_bus_fabric_if.slave  cpu,
  mmio_bus_fabric_if.master slv
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic [1:0]            r_state,  w_state_nxt;
  logic [NUM_SLAVES-1:0] r_sel,    w_sel_nxt;
  logic                  r_we,     w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,   w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,  w_wdata_nxt;
  logic [DATA_WIDTH-1:0] r_rdata,  w_rdata_nxt;
  logic                  r_ready,  w_ready_nxt;
  logic                  r_error,  w_error_nxt;
  logic [IDX_W-1:0]      r_idx,    w_idx_nxt;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_hit_idx;
  logic                  w_slv_done;
  logic                  w_timeout;

  // Scan from the top so the lowest matching window overrides the rest.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((cpu.cpu_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_slv_done = slv.slv_ready[r_idx];

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_state != S_ACCESS) begin
      r_cnt <= '0;
    end else if (!w_slv_done && (r_cnt != CNT_W'(TIMEOUT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A slave completion in the same cycle as the timeout still wins.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu.cpu_req) begin
          w_state_nxt = w_hit ? S_ACCESS : S_ERROR;
        end
      end
      S_ACCESS: begin
        if (w_slv_done) begin
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      S_ERROR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt   = r_sel;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_idx_nxt   = r_idx;
    w_ready_nxt = 1'b0;
    w_error_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu.cpu_req) begin
          w_addr_nxt  = cpu.cpu_addr;
          w_wdata_nxt = cpu.cpu_wdata;
          w_we_nxt    = cpu.cpu_we & w_hit;
          w_idx_nxt   = w_hit_idx;
          w_sel_nxt   = w_hit ? (NUM_SLAVES'(1) << w_hit_idx) : '0;
        end
      end
      S_ACCESS: begin
        if (w_slv_done || w_timeout) begin
          w_sel_nxt = '0;
          w_we_nxt  = 1'b0;
        end
        if (w_slv_done && !r_we) begin
          w_rdata_nxt = slv.slv_rdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      S_RESP: begin
        w_ready_nxt = 1'b1;
      end
      S_ERROR: begin
        w_ready_nxt = 1'b1;
        w_error_nxt = 1'b1;
        w_rdata_nxt = '1;
        w_sel_nxt   = '0;
        w_we_nxt    = 1'b0;
      end
      default: begin
        w_sel_nxt = '0;
        w_we_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_ready <= w_ready_nxt;
      r_error <= w_error_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign cpu.cpu_rdata = r_rdata;
  assign cpu.cpu_ready = r_ready;
  assign cpu.cpu_error = r_error;
  assign slv.slv_sel   = r_sel;
  assign slv.slv_we    = r_we;
  assign slv.slv_addr  = r_addr;
  assign slv.slv_wdata = r_wdata;

endmodule

`default_nettype wire

// File: doc/mmio_bus_fabric.md
# mmio_bus_fabric

Parametrised CPU-to-peripheral interconnect that replaces the fixed point-to-point wiring between the multi-cycle CPU and its single RAM. A single CPU request port is decoded against NUM_SLAVES base/mask windows, forwarded to one selected slave with a ready handshake, and answered with read data, a one-cycle ready strobe and an error flag. It sits between the CPU's memory port and the RAM, terminal text buffer and future MMIO peripherals.

## Interface
- NUM_SLAVES, 4, number of slave windows (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed bases, slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- SLAVE_MASK, {NUM_SLAVES{32'h0}}, packed masks; hit when (addr & mask) == base
- TIMEOUT, 255, max ACCESS cycles before error (used only with MMIO_TIMEOUT_EN)

Ports:
- clock  in  1  single clock; all state on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  request; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  request address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_rdata  out  DATA_WIDTH  read data, valid with cpu_ready
- cpu_ready  out  1  one-cycle completion strobe
- cpu_error  out  1  decode miss or timeout, valid with cpu_ready
- slv_sel  out  NUM_SLAVES  one-hot slave select
- slv_we  out  1  write enable to selected slave
- slv_addr  out  ADDR_WIDTH  registered address
- slv_wdata  out  DATA_WIDTH  registered write data
- slv_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data
- slv_ready  in  NUM_SLAVES  per-slave completion

## Operation
- States: IDLE, ACCESS, RESP, ERROR.
- IDLE: on cpu_req=1 register cpu_we/addr/wdata into slv_we/slv_addr/slv_wdata and decode. Hit -> ACCESS with slv_sel one-hot on winning index; miss -> ERROR.
- Decode priority: lowest hitting index wins on overlapping windows.
- ACCESS: slv_sel and slv_we held stable. When slv_ready[idx]=1, capture slv_rdata slice idx into cpu_rdata (reads only; writes leave cpu_rdata unchanged), drop slv_sel/slv_we -> RESP. slv_ready of unselected slaves ignored.
- RESP: cpu_ready=1, cpu_error=0 for exactly one cycle -> IDLE.
- ERROR: cpu_ready=1, cpu_error=1, cpu_rdata = all ones for one cycle; slv_sel=0 -> IDLE.
- cpu_req outside IDLE ignored; no queuing. Requester holds request until cpu_ready or deasserts; a new request is accepted the cycle after RESP/ERROR.
- reset_n low at any point: immediate return to IDLE, in-flight access abandoned, no ready strobe.

## Timing
- Reset values: cpu_rdata=0, cpu_ready=0, cpu_error=0, slv_sel=0, slv_we=0, slv_addr=0, slv_wdata=0, state IDLE.
- All outputs registered.
- Hit, slave ready in first ACCESS cycle: req sampled at edge 0, slv_sel high after edge 0, cpu_ready high after edge 2 (2-cycle latency); each extra slave wait cycle adds one.
- Miss: cpu_ready/cpu_error high after edge 1 (1-cycle latency).
- Back-to-back: max one transaction per 3 cycles (hit) / 2 cycles (miss).

## Configuration
- MMIO_TIMEOUT_EN defined: ACCESS counter, width clog2(TIMEOUT+1), cleared on entry, incremented each ACCESS cycle without slv_ready; when it reaches TIMEOUT, deselect and go ERROR. slv_ready in the same cycle the count reaches TIMEOUT wins (normal RESP).
- Not defined: no counter; ACCESS waits indefinitely; TIMEOUT unused.

## Test plan
- Reset: reset_n low mid-ACCESS -> all outputs 0 immediately, IDLE; post-reset read completes normally.
- Read hit: slave 1 base 0x1000 mask 0xF000, read 0x1004, slv_ready[1] same cycle returning 0xCAFEF00D -> cpu_ready after 2 cycles, cpu_rdata=0xCAFEF00D, cpu_error=0, slv_sel=4'b0010.
- Write with waits: write 0x12345678 to slave 0 with ready after 3 cycles -> slv_we=1, slv_wdata=0x12345678 held 3 cycles, cpu_ready at cycle 4, cpu_rdata unchanged.
- Decode miss: address 0xF0000000 matching no window -> cpu_ready and cpu_error after 1 cycle, cpu_rdata=0xFFFFFFFF, slv_sel never asserted.
- Overlap priority: slaves 0 and 2 both hit 0x0 -> slv_sel=4'b0001 only.
- Timeout (MMIO_TIMEOUT_EN, TIMEOUT=4): slave never ready -> slv_sel dropped, cpu_error=1 with cpu_ready 6 cycles after request; ready on 4th ACCESS cycle -> normal completion.
